// File: rtl/counter_param_pkg.sv
// rtl/counter_param_pkg.sv - shared operation encodings for the counter_param family
package counter_param_pkg;

  // Operation select shared by every counter in the family
  typedef enum logic [1:0] {
    MODO_UP   = 2'b00,
    MODO_DOWN = 2'b01,
    MODO_STEP = 2'b10,
    MODO_LOAD = 2'b11
  } modo_e;

  // Default geometry of the family's reference counter
  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;
  localparam int DEF_STEP  = 3;

  // True for the operations that add to the count
  function automatic logic is_add_op(input modo_e op);
    return (op == MODO_UP) || (op == MODO_STEP);
  endfunction

endpackage

// File: rtl/counter_param_if.sv
// rtl/counter_param_if.sv - control and status bundle of counter_param
interface counter_param_if
  import counter_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
);
  localparam int NSEG = WIDTH / SEG;

  logic              enb;
  modo_e             modo;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              rco;
  logic [NSEG-1:0]   seg_co;

  modport master (output enb, modo, d, input q, rco, seg_co);
  modport slave  (input enb, modo, d, output q, rco, seg_co);
endinterface

// File: rtl/counter_param_seg.sv
// rtl/counter_param_seg.sv - one SEG-bit slice of the counter with carry/borrow chaining
module counter_param_seg
  import counter_param_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  modo_e          op,
  input  logic [SEG-1:0] q_slice,
  input  logic [SEG-1:0] add_slice,
  input  logic [SEG-1:0] d_slice,
  input  logic           ci,
  output logic [SEG-1:0] nxt,
  output logic           co
);

  logic [SEG:0] wide;

  // Slice arithmetic: ci is a carry for adds and a borrow for the subtract
  always_comb begin
    wide = '0;
    nxt  = q_slice;
    co   = 1'b0;
    if (op == MODO_LOAD) begin
      nxt = d_slice;
      co  = 1'b0;
    end else if (op == MODO_DOWN) begin
      // A negative result leaves the top bit set, which is exactly the borrow
      wide = {1'b0, q_slice} - {1'b0, add_slice} - {{SEG{1'b0}}, ci};
      nxt  = wide[SEG-1:0];
      co   = wide[SEG];
    end else if (is_add_op(op)) begin
      wide = {1'b0, q_slice} + {1'b0, add_slice} + {{SEG{1'b0}}, ci};
      nxt  = wide[SEG-1:0];
      co   = wide[SEG];
    end
  end

endmodule

// File: rtl/counter_param.sv
// rtl/counter_param.sv - segmented up/down/step/load counter; COUNTER_PARAM_SAT_EN selects saturation
module counter_param
  import counter_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG,
  parameter int STEP  = DEF_STEP
) (
  input  logic            clk,
  input  logic            rst,
  counter_param_if.slave  bus
);

  localparam int               NSEG   = WIDTH / SEG;
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic [WIDTH-1:0] q_r;
  logic             rco_r;
  logic [NSEG-1:0]  seg_co_r;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_upd;
  logic [NSEG:0]    chain;

  // Operand fed to the segment chain; down uses 1 as the subtrahend
  always_comb begin
    addend = '0;
    case (bus.modo)
      MODO_UP, MODO_DOWN: addend = WIDTH'(1);
      MODO_STEP:          addend = STEP_V;
      default:            addend = '0;
    endcase
  end

  assign chain[0] = 1'b0;

  genvar k;
  generate
    for (k = 0; k < NSEG; k++) begin : g_seg
      counter_param_seg #(.SEG(SEG)) u_seg (
        .op        (bus.modo),
        .q_slice   (q_r[k*SEG +: SEG]),
        .add_slice (addend[k*SEG +: SEG]),
        .d_slice   (bus.d[k*SEG +: SEG]),
        .ci        (chain[k]),
        .nxt       (q_nxt[k*SEG +: SEG]),
        .co        (chain[k+1])
      );
    end
  endgenerate

  // Final count: wrapped result, or clamped to the limit when saturation is built in
  always_comb begin
    q_upd = q_nxt;
`ifdef COUNTER_PARAM_SAT_EN
    if (chain[NSEG]) begin
      q_upd = (bus.modo == MODO_DOWN) ? '0 : '1;
    end
`endif
  end

  // State register; flags are one-cycle pulses and clear whenever counting is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r      <= '0;
      rco_r    <= 1'b0;
      seg_co_r <= '0;
    end else if (!bus.enb) begin
      rco_r    <= 1'b0;
      seg_co_r <= '0;
    end else begin
      q_r      <= q_upd;
      rco_r    <= chain[NSEG];
      seg_co_r <= chain[NSEG:1];
    end
  end

  assign bus.q      = q_r;
  assign bus.rco    = rco_r;
  assign bus.seg_co = seg_co_r;

endmodule
